uart_rx_os: RTL
===============

// Module: uart_rx_os
// PURPOSE
//  Second-generation UART receiver: oversampled, mid-bit sampling, parametrised frame format
//  (data width, parity, stop bits) with parity/framing/overrun error reporting and a rdy/ack
//  handshake. Sits between the async serial pin and the bus-side register block; replaces the
//  one-clock-per-bit receiver, which had no synchroniser, no glitch rejection and no errors.
// PARAMETERS
//  DATA_BITS  8   payload bits per frame, 5..9, LSB first
//  OVERSAMPLE 16  clk cycles per bit period, even, >=4
//  PARITY     0   0 none, 1 even, 2 odd
//  STOP_BITS  1   1 or 2 stop bits checked
// PORTS
//  clk        in   1          single clock, all logic rising edge
//  rst_n      in   1          asynchronous, active-low reset
//  en         in   1          receive enable; low = idle/abort
//  x          in   1          serial line, async, idle high
//  ack        in   1          consumer accepts data; clears rdy and the error flags
//  rdy        out  1          frame held in data, valid until ack
//  data       out  DATA_BITS  received payload
//  parity_err out  1          parity mismatch on held frame
//  frame_err  out  1          a stop bit sampled 0 on held frame
//  overrun    out  1          sticky: un-acked frame was overwritten
// BEHAVIOUR
//  - Reset: every output 0; FSM IDLE; bit/sample counters 0; sync flops 1.
//  - x passes a 2-flop synchroniser (xs). All decisions use xs only.
//  - FSM: IDLE -> START -> DATA -> [PARITY] -> STOP -> IDLE.
//    IDLE: en=1 and xs 1->0 edge -> START, sample counter cleared.
//    START: after OVERSAMPLE/2 cycles sample xs. 0 = valid -> DATA. 1 = glitch -> IDLE, nothing reported.
//    DATA: sample every OVERSAMPLE cycles, shift in LSB first. After DATA_BITS samples ->
//          PARITY, or STOP if PARITY=0.
//    PARITY: one sample, compared with XOR of payload (even), or its inverse (odd).
//    STOP: STOP_BITS samples. Any 0 sets the frame_err candidate. After the last sample:
//          commit, -> IDLE. No wait for a full stop period, so back-to-back frames are accepted.
//  - Latency: the falling edge on x is seen on xs 2 cycles later. rdy rises on the cycle after
//    the final stop sample, which comes OVERSAMPLE/2 + (DATA_BITS+(PARITY!=0)+STOP_BITS)*OVERSAMPLE
//    cycles after START entry.
//  - Commit in one cycle: data <= payload, parity_err/frame_err <= candidates, rdy <= 1.
//  - Handshake: rdy stays high until ack. ack with rdy=1 clears rdy, parity_err, frame_err and
//    overrun next cycle. ack with rdy=0 is ignored.
//  - Commit while rdy=1 and no ack that cycle: data and errors overwritten, overrun <= 1, rdy stays 1.
//  - Commit and ack in the same cycle: the new frame wins. rdy stays 1, overrun 0, error flags
//    taken from the new frame.
//  - en low in any state: FSM -> IDLE next cycle, partial frame discarded. rdy, data and flags
//    hold and remain ackable. en rising while xs=0 does not start a frame; a 1->0 edge is required.
//  - rst_n low mid-frame: immediate return to reset values, no partial commit.
//  - Counter widths: $clog2(OVERSAMPLE) sample counter, $clog2(DATA_BITS+1) bit counter.
//    No wrap past the terminal count.
// STRUCTURE
//  - Shared package uart_pkg: PARITY_NONE/EVEN/ODD constants; FSM state encoding
//    (ST_IDLE, ST_START, ST_DATA, ST_PARITY, ST_STOP); helper function for the expected parity bit.
//    The transmitter successor uses the same package.
//  - One sub-module, uart_os_tick: sample counter with clear/enable. Emits a mid-bit strobe at
//    OVERSAMPLE/2 and then every OVERSAMPLE. The FSM, shift register and output registers stay top-level.
// TESTING (bench runs OVERSAMPLE=4, DATA_BITS=8 unless noted; task drives a frame at 4 clk/bit)
//  1 Reset/idle: rst_n low, then en=1, x=1 for 100 cycles -> rdy=0, data=0, all error flags 0.
//  2 Disabled: en=0, full frame 0x1C -> rdy stays 0. Then en=1, frame 0xA5 -> rdy=1, data=0xA5,
//    no errors; ack -> rdy=0 next cycle.
//  3 Glitch: x low for 1 cycle (below OVERSAMPLE/2) -> FSM back to IDLE, rdy=0. The next valid
//    frame 0x3C is received correctly.
//  4 Errors (PARITY=1): frame 0x07 with parity bit 0 -> rdy=1, parity_err=1. Frame 0x55 with
//    stop bit 0 -> frame_err=1, parity_err=0.
//  5 Overrun: frames 0x11 then 0x22 with no ack -> data=0x22, overrun=1. Ack asserted on the
//    commit cycle of 0x33 -> rdy=1, data=0x33, overrun=0.
//  6 Abort: en drops after data bit 3 of 0xF0 -> no commit, rdy=0. rst_n pulsed mid-frame ->
//    all outputs 0 within the same cycle.

Source files
------------

// File: rtl/uart_pkg.sv
// uart_pkg: shared UART constants, FSM encoding and parity helper
package uart_pkg;
  localparam int PARITY_NONE = 0;
  localparam int PARITY_EVEN = 1;
  localparam int PARITY_ODD  = 2;
  typedef enum logic [2:0] {ST_IDLE, ST_START, ST_DATA, ST_PARITY, ST_STOP} state_t;
  function automatic logic parity_bit(input logic xr, input int mode);
    return (mode == PARITY_ODD) ? ~xr : xr;
  endfunction
endpackage

// File: rtl/uart_os_tick.sv
// uart_os_tick: oversample counter, strobes at mid-bit then once per bit period
module uart_os_tick #(
  parameter int OVERSAMPLE = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic tick
);
  localparam int W = $clog2(OVERSAMPLE);
  logic [W-1:0] cnt;
  logic         first;
  assign tick = en & (cnt == (first ? W'(OVERSAMPLE / 2 - 1) : W'(OVERSAMPLE - 1)));
  // first strobe after half a period lands mid-start-bit; later ones a full period apart
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      cnt   <= '0;
      first <= 1'b1;
    end else if (clr) begin
      cnt   <= '0;
      first <= 1'b1;
    end else if (en) begin
      cnt   <= tick ? '0 : cnt + W'(1);
      first <= tick ? 1'b0 : first;
    end
endmodule

// File: rtl/uart_rx_os.sv
// uart_rx_os: oversampled UART receiver with parity/framing/overrun flags and rdy/ack
module uart_rx_os
  import uart_pkg::*;
#(
  parameter int DATA_BITS  = 8,
  parameter int OVERSAMPLE = 16,
  parameter int PARITY     = 0,
  parameter int STOP_BITS  = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 en,
  input  logic                 x,
  input  logic                 ack,
  output logic                 rdy,
  output logic [DATA_BITS-1:0] data,
  output logic                 parity_err,
  output logic                 frame_err,
  output logic                 overrun
);
  localparam int BW = $clog2(DATA_BITS + 1);
  state_t               state;
  logic                 sync1, xs, xs_d;
  logic [BW-1:0]        bcnt;
  logic [DATA_BITS-1:0] sh;
  logic                 pe, fe, tick;
  uart_os_tick #(.OVERSAMPLE(OVERSAMPLE)) u_tick (
    .clk  (clk),
    .rst_n(rst_n),
    .clr  (state == ST_IDLE),
    .en   (state != ST_IDLE),
    .tick (tick)
  );
  // synchroniser, frame FSM, shift register and held output registers
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      sync1      <= 1'b1;
      xs         <= 1'b1;
      xs_d       <= 1'b1;
      state      <= ST_IDLE;
      bcnt       <= '0;
      sh         <= '0;
      pe         <= 1'b0;
      fe         <= 1'b0;
      rdy        <= 1'b0;
      data       <= '0;
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      sync1 <= x;
      xs    <= sync1;
      xs_d  <= xs;
      if (ack && rdy) begin
        rdy        <= 1'b0;
        parity_err <= 1'b0;
        frame_err  <= 1'b0;
        overrun    <= 1'b0;
      end
      if (!en) state <= ST_IDLE;
      else
        case (state)
          ST_IDLE: if (xs_d && !xs) state <= ST_START;
          ST_START:
            if (tick) begin
              state <= xs ? ST_IDLE : ST_DATA;
              bcnt  <= '0;
              pe    <= 1'b0;
              fe    <= 1'b0;
            end
          ST_DATA:
            if (tick) begin
              sh   <= {xs, sh[DATA_BITS-1:1]};
              bcnt <= (bcnt == BW'(DATA_BITS - 1)) ? '0 : bcnt + BW'(1);
              if (bcnt == BW'(DATA_BITS - 1)) state <= (PARITY != PARITY_NONE) ? ST_PARITY : ST_STOP;
            end
          ST_PARITY:
            if (tick) begin
              pe    <= xs != parity_bit(^sh, PARITY);
              state <= ST_STOP;
            end
          ST_STOP:
            if (tick) begin
              bcnt <= bcnt + BW'(1);
              fe   <= fe | ~xs;
              if (bcnt == BW'(STOP_BITS - 1)) begin
                state      <= ST_IDLE;
                data       <= sh;
                parity_err <= pe;
                frame_err  <= fe | ~xs;
                overrun    <= rdy & ~ack;
                rdy        <= 1'b1;
              end
            end
          default: state <= ST_IDLE;
        endcase
    end
endmodule
